// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational conditional two's-complement negate; used for operand magnitudes and result sign fix.
module muldiv_abs
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? -x : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiply exits as soon as the remaining multiplier bits are zero.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output state_t           dbg_state
);

   // Handshake: start is taken only while busy is low (IDLE); while busy is high
   // start and MTHI/MTLO writes are ignored, and done pulses for one cycle as hi/lo load.
   state_t               state, state_nxt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     md, mr;
   logic [CNT_W-1:0]     cnt;
   logic                 is_mul, neg_lo, neg_hi;

   logic [WIDTH-1:0]     a_mag, b_mag;
   logic                 b_zero;
   logic [WIDTH:0]       mul_sum, rem_sh, trial;
   logic [2*WIDTH-1:0]   mul_acc_nxt, div_acc_nxt, prod_sh, prod_fix;
   logic [WIDTH-1:0]     mr_nxt, quo_fix, rem_fix;
   logic                 mul_last;

   muldiv_abs #(.WIDTH(WIDTH)) u_abs_a (.x(a), .neg(op[0] & a[WIDTH-1]), .y(a_mag));
   muldiv_abs #(.WIDTH(WIDTH)) u_abs_b (.x(b), .neg(op[0] & b[WIDTH-1]), .y(b_mag));

   assign b_zero = (b == '0);

   // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
   assign mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mr[0] ? {1'b0, md} : '0);
   assign mul_acc_nxt = {mul_sum, acc[WIDTH-1:1]};
   assign mr_nxt      = mr >> 1;

   // Divide: acc holds {remainder, dividend/quotient}; restoring trial subtract.
   assign rem_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign trial       = rem_sh - {1'b0, md};
   assign div_acc_nxt = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   // An early-exited product still sits cnt bits high in the accumulator.
   assign prod_sh = acc >> cnt;

   muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_p (.x(prod_sh), .neg(neg_lo), .y(prod_fix));
   muldiv_abs #(.WIDTH(WIDTH))   u_fix_q (.x(acc[WIDTH-1:0]), .neg(neg_lo), .y(quo_fix));
   muldiv_abs #(.WIDTH(WIDTH))   u_fix_r (.x(acc[2*WIDTH-1:WIDTH]), .neg(neg_hi), .y(rem_fix));

`ifdef MULDIV_EARLY_OUT_EN
   assign mul_last = (cnt == CNT_W'(1)) || (mr_nxt == '0);
`else
   assign mul_last = (cnt == CNT_W'(1));
`endif

   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      done      = (state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               if (op[1]) begin
                  state_nxt = b_zero ? FIX : DIV;
               end else begin
`ifdef MULDIV_EARLY_OUT_EN
                  state_nxt = (b_mag == '0) ? FIX : MUL;
`else
                  state_nxt = MUL;
`endif
               end
            end
         end
         MUL:     if (mul_last) state_nxt = FIX;
         DIV:     if (cnt == CNT_W'(1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc      <= '0;
         md       <= '0;
         mr       <= '0;
         cnt      <= '0;
         is_mul   <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_hi) hi <= wdata;
               if (wr_lo) lo <= wdata;
               if (start) begin
                  cnt      <= CNT_W'(WIDTH);
                  is_mul   <= ~op[1];
                  md       <= op[1] ? b_mag : a_mag;
                  mr       <= b_mag;
                  div_zero <= op[1] & b_zero;
                  if (op[1] && b_zero) begin
                     // Divide by zero: result is preloaded raw and passes FIX untouched.
                     acc    <= {a, {WIDTH{1'b1}}};
                     neg_lo <= 1'b0;
                     neg_hi <= 1'b0;
                  end else begin
                     acc    <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                     neg_lo <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_hi <= op[0] & op[1] & a[WIDTH-1];
                  end
               end
            end
            MUL: begin
               acc <= mul_acc_nxt;
               mr  <= mr_nxt;
               cnt <= cnt - CNT_W'(1);
            end
            DIV: begin
               acc <= div_acc_nxt;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: acc <= is_mul ? prod_fix : {rem_fix, quo_fix};
            DONE: begin
               hi <= acc[2*WIDTH-1:WIDTH];
               lo <= acc[WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: scoreboard of expected {hi,lo}, latency and flag checks.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk, reset, start, wr_hi, wr_lo;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   state_t      dbg_state;

   logic [63:0] exp_q[$];
   logic [31:0] model_hi, model_lo;
   int          errors, checks;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      logic signed [31:0] dx, dy;
      case (o)
         OP_MULTU: return {32'd0, x} * {32'd0, y};
         OP_MULT: begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
         end
         OP_DIVU: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            dx = x;
            dy = y;
            return {32'(dx % dy), 32'(dx / dy)};
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] m;
      int msb;
`endif
      if (o[1]) return (y == 0) ? 2 : 34;
`ifdef MULDIV_EARLY_OUT_EN
      m = (o[0] && y[31]) ? -y : y;
      if (m == 0) return 2;
      msb = 0;
      for (int i = 0; i < 32; i++) if (m[i]) msb = i;
      return msb + 3;
`else
      return 34;
`endif
   endfunction

   // Called at a negedge; returns at a negedge once the result is visible.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit collide, input bit wr_start);
      logic [63:0] e;
      int cyc, lat;
      bit got;
      exp_q.push_back(model(o, x, y));
      lat = exp_lat(o, y);
      op = o; a = x; b = y; start = 1'b1;
      if (wr_start) begin wr_hi = 1'b1; wdata = 32'h77; end
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 100) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0; wr_hi = 1'b0;
            a = $urandom; b = $urandom;
            check("busy_cycle1", busy, 1);
            if (wr_start) check("wr_at_start", hi, 32'h77);
         end
         if (collide && cyc == 5) begin
            start = 1'b1; op = OP_DIVU; wr_hi = 1'b1; wdata = 32'hAA;
         end
         if (collide && cyc == 6) begin start = 1'b0; wr_hi = 1'b0; end
         if (collide && cyc == 7) check("dropped_wr_hi", hi, model_hi);
         if (done) got = 1'b1;
      end
      start = 1'b0; wr_hi = 1'b0;
      check("done_seen", got, 1);
      check("latency", cyc, lat);
      check("div_zero", div_zero, (o[1] && y == 0));
      @(posedge clk); @(negedge clk);
      check("busy_after", busy, 0);
      check("done_pulse", done, 0);
      e = exp_q.pop_front();
      check("result", {hi, lo}, e);
      model_hi = e[63:32];
      model_lo = e[31:0];
   endtask

   initial begin
      int cyc;
      errors = 0; checks = 0;
      model_hi = '0; model_lo = '0;
      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_div_zero", div_zero, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_state", dbg_state, IDLE);
      reset = 1'b1;
      @(negedge clk);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0);
      check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op(OP_DIVU, 32'h1234, 32'd0, 0, 0);
      check("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
      check("div_zero_sticky", div_zero, 1);
      run_op(OP_DIVU, 32'd10, 32'd3, 0, 0);
      check("divu_10_3", {hi, lo}, 64'h0000_0001_0000_0003);
      check("div_zero_cleared", div_zero, 0);
      run_op(OP_MULTU, 32'd2, 32'd3, 0, 1);
      run_op(OP_MULTU, 32'd5, 32'd6, 1, 0);
      check("collide_result", {hi, lo}, 64'd30);

      wr_lo = 1'b1; wdata = 32'h55;
      @(posedge clk); @(negedge clk);
      wr_lo = 1'b0;
      check("mtlo_idle", lo, 32'h55);
      check("mtlo_hi_kept", hi, model_hi);

      op = OP_DIV; a = 32'd1000; b = 32'd7; start = 1'b1;
      cyc = 0;
      while (cyc < 10) begin
         @(posedge clk); @(negedge clk);
         cyc++;
         start = 1'b0;
      end
      check("pre_reset_busy", busy, 1);
      reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_state", dbg_state, IDLE);
      model_hi = '0; model_lo = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_op(OP_MULTU, 32'd9, 32'd1, 0, 0);
      run_op(OP_MULT, 32'd0, 32'hFFFF_FFFF, 0, 0);
      for (int i = 0; i < 8; i++) begin
         run_op(2'($urandom_range(0, 3)), $urandom,
                (i == 3) ? 32'd0 : 32'($urandom_range(0, 32'hFFFF)), 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
